// File: rtl/arb4_rr_ctrl.sv
// Four-requester round-robin arbiter with registered one-hot grant and encoded index.
// Optional hold-limit revocation is compiled in with `define ARB_HOLD_TIMEOUT_EN.
module arb4_rr_ctrl #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255 || (64'd1 << CNT_W) <= 64'(HOLD_MAX)) begin : g_param_chk
    $error("arb4_rr_ctrl: HOLD_MAX must be 1..255 and fit in CNT_W bits");
  end

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic [1:0] last_q, last_d;

  logic [7:0] req_dbl;
  logic [3:0] req_rot;
  logic [1:0] pick_off;
  logic [1:0] pick_id;
  logic       owner_rel;

  // Rotate so bit 0 is the requester just after the last one served.
  always_comb begin
    req_dbl = {req, req};
    req_rot = req_dbl[3'(last_q) + 3'd1 +: 4];
    if (req_rot[0])      pick_off = 2'd0;
    else if (req_rot[1]) pick_off = 2'd1;
    else if (req_rot[2]) pick_off = 2'd2;
    else                 pick_off = 2'd3;
    pick_id = last_q + 2'd1 + pick_off;
  end

  assign owner_rel = done || !req[gnt_id_q];

`ifdef ARB_HOLD_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    last_d   = last_q;
`ifdef ARB_HOLD_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          gnt_d    = 4'b0001 << pick_id;
          gnt_id_d = pick_id;
          last_d   = pick_id;
          state_d  = StBusy;
`ifdef ARB_HOLD_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      StBusy: begin
        if (owner_rel) begin
          gnt_d   = 4'b0000;
          state_d = StIdle;
`ifdef ARB_HOLD_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(HOLD_MAX - 1)) begin
          // Revoke; last_q already points at the owner, so it drops to lowest priority.
          gnt_d     = 4'b0000;
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      gnt_q    <= 4'b0000;
      gnt_id_q <= 2'd0;
      last_q   <= 2'd3;
`ifdef ARB_HOLD_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      last_q   <= last_d;
`ifdef ARB_HOLD_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = |gnt_q;
`ifdef ARB_HOLD_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_arb4_rr_ctrl.sv
// Self-checking bench for arb4_rr_ctrl: vector table plus hand-written corner sequences,
// with expected outputs queued at drive time and popped after the clock edge.
module tb_arb4_rr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  always #5 clk = ~clk;

  arb4_rr_ctrl #(
    .HOLD_MAX(4),
    .CNT_W   (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  typedef struct {
    logic       r;
    logic [3:0] rq;
    logic       d;
    logic [3:0] eg;
    logic [1:0] eid;
    logic       cid;
    logic       eto;
  } vec_t;

  typedef struct {
    logic [3:0] eg;
    logic [1:0] eid;
    logic       cid;
    logic       eto;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[17];

  // Drive one cycle of inputs, queue the outputs expected after the edge, then check them.
  task automatic step(input logic r, input logic [3:0] rq, input logic d, input logic [3:0] eg,
                      input logic [1:0] eid, input logic cid, input logic eto, input string nm);
    exp_t e;
    @(negedge clk);
    rst  = r;
    req  = rq;
    done = d;
    e.eg = eg; e.eid = eid; e.cid = cid; e.eto = eto; e.name = nm;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    n_vec++;
    if (gnt !== e.eg || gnt_valid !== (|e.eg) || timeout !== e.eto ||
        (e.cid && gnt_id !== e.eid)) begin
      n_err++;
      $display("FAIL %s: got gnt=%b id=%0d valid=%b timeout=%b, want gnt=%b id=%0d valid=%b timeout=%b",
               e.name, gnt, gnt_id, gnt_valid, timeout, e.eg, e.eid, |e.eg, e.eto);
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    repeat (2) @(posedge clk);

    // Full rotation with req=1111, then alternating pair req=1010.
    vecs[0]  = '{1'b1, 4'hF, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 4'hF, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 4'hF, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 4'hF, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 4'hF, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'hF, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 4'hF, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 4'hF, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 4'hF, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'hF, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 4'hA, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 4'hA, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 4'hA, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 4'hA, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 4'hA, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 4'hA, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 4'hA, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].r, vecs[i].rq, vecs[i].d, vecs[i].eg, vecs[i].eid, vecs[i].cid, vecs[i].eto,
           $sformatf("table[%0d]", i));
    end

    // Non-owner requests during a grant are ignored; served owner becomes lowest priority.
    step(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, "hold_reset");
    step(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "hold_grant2");
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b1101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, $sformatf("hold_keep%0d", i));
    end
    step(1'b0, 4'b1101, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "hold_done");
    step(1'b0, 4'b1101, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, "hold_next3");

    // Owner drops request without done; done while idle does nothing.
    step(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, "drop_reset");
    step(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "drop_grant1");
    step(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "drop_release");
    step(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "drop_idle_done");
    step(1'b0, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, "idle_done_ignored");
    step(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "done_and_drop");

    // Single persistent requester: grant, release, dead cycle, grant.
    step(1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "solo_grant");
    step(1'b0, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "solo_done");
    step(1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "solo_regrant");

    // Reset mid-grant clears everything and restores the pointer.
    step(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, "mid_reset0");
    step(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "mid_grant2");
    step(1'b1, 4'b0100, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, "mid_reset");
    step(1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "mid_first0");

    // Hold limit behaviour.
    step(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, "to_reset");
`ifdef ARB_HOLD_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, $sformatf("to_hold%0d", i));
    end
    step(1'b0, 4'b0011, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, "to_pulse");
    step(1'b0, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "to_next1");
`else
    for (int i = 0; i < 55; i++) begin
      step(1'b0, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, $sformatf("nolimit_hold%0d", i));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arb4_rr_ctrl.md
# arb4_rr_ctrl

Four-requester round-robin arbiter that shares one downstream resource (the 4-to-2 priority-encoded select path) among requesters 0–3. It issues a registered one-hot grant plus the matching 2-bit encoded index, holds the grant until the owner finishes, then rotates priority. It sits between the requester bank and the shared datapath, replacing the fixed-priority encoder select with fair, sequenced access.

## Interface
Parameters:
- HOLD_MAX, 15, maximum grant duration in cycles when the timeout is compiled in (1..255)
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > HOLD_MAX

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  4  request lines, bit i = requester i, level-sensitive
- done  in  1  owner finished; valid only while gnt_valid=1
- gnt  out  4  one-hot grant, registered
- gnt_id  out  2  encoded index of granted requester (A1:A0 equivalent)
- gnt_valid  out  1  a grant is active
- timeout  out  1  one-cycle pulse when a grant is revoked by the hold limit

## Operation
- States: IDLE, BUSY. Reset → IDLE.
- Reset values: gnt=4'b0000, gnt_id=2'b00, gnt_valid=0, timeout=0, last pointer=3, hold counter=0.
- IDLE: if req≠0, select first set bit searching last+1, last+2, last+3, last (mod 4); register gnt/gnt_id/gnt_valid, set last=selected index, clear counter, → BUSY. If req=0, stay; outputs remain 0.
- BUSY: grant held constant. Release when done=1 or req[gnt_id]=0 (requester drops) → clear gnt, gnt_valid, → IDLE. gnt_id retains last value (don't-care when gnt_valid=0).
- done and request drop in same cycle: single release, identical behaviour.
- Requests from non-owners during BUSY are ignored (not queued); they compete at next IDLE arbitration.
- Rotation: after reset, first search order 0,1,2,3. Requester just served becomes lowest priority.
- Single persistent requester: re-granted every other cycle (grant, release, IDLE, grant).
- gnt is always one-hot or zero; gnt_valid = |gnt.
- rst asserted in any state, including mid-grant: all outputs and pointer return to reset values next edge; no timeout pulse.

## Timing
- Arbitration latency: req sampled in IDLE at edge n → gnt valid after edge n (visible cycle n+1).
- Release: done sampled at edge m → gnt=0 in cycle m+1; earliest next grant cycle m+2. Minimum one dead cycle between consecutive grants.
- done asserted while gnt_valid=0 is ignored.
- Hold counter increments each BUSY cycle; only meaningful with timeout compiled in.

## Configuration
- Macro ARB_HOLD_TIMEOUT_EN.
- Defined: if a grant has been held HOLD_MAX cycles (counter reaches HOLD_MAX-1 with no release), the next edge forces release, drives timeout=1 for exactly one cycle, → IDLE; pointer already advanced so the revoked requester is lowest priority. If done/drop coincides with the limit, it is a normal release, timeout stays 0.
- Not defined: no counter logic; grants held indefinitely until done or request drop; timeout tied to 0.

## Test plan
- Reset then req=4'b1111 → gnt=0001, gnt_id=0 one cycle later; done each grant → sequence 0001, 0010, 0100, 1000, 0001 with one idle cycle between.
- req=4'b1010 from reset → grant 1 (0010, gnt_id=1); after done, grant 3 (1000, gnt_id=3); then 1 again.
- During grant to 2, assert req[0] and req[3]; hold 5 cycles → gnt stays 0100; after done, next grant is 3 (1000).
- Owner drops req[1] without done → gnt=0000 next cycle, gnt_valid=0; done asserted in IDLE has no effect.
- rst pulsed mid-grant (gnt=0100) → all outputs 0 next cycle; with req=1111 afterward first grant is 0001.
- With ARB_HOLD_TIMEOUT_EN, HOLD_MAX=4, req=0011, no done → gnt=0001 for 4 cycles, timeout=1 for one cycle as gnt clears, then gnt=0010; without macro gnt=0001 held 50+ cycles, timeout never asserts.
